// File: rtl/ysyx_lsu_ldresp.sv
// ysyx_lsu_ldresp: answers EXU load requests. It issues a word-aligned read on the
// memory port, then aligns and extends the returned word, and flags misaligned
// accesses and bus errors. Optional macro YSYX_LSU_LDRESP_LASTWORD_EN adds a
// one-entry last-word buffer that serves repeated aligned loads without a memory read.
// Every output is registered, so a response is formed on the edge that enters RESP.
// A flush in the cycle that would create a response therefore stops that response.
module ysyx_lsu_ldresp #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] FAULT_DATA = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            exu_rvalid,
  input  logic [XLEN-1:0] exu_raddr,
  input  logic [4:0]      exu_ralu,
  input  logic [XLEN-1:0] exu_pc,
  output logic [XLEN-1:0] exu_rdata,
  output logic            exu_rready,
  output logic            ld_fault,
  output logic [XLEN-1:0] ld_fault_pc,
  output logic            mem_arvalid,
  output logic [XLEN-1:0] mem_araddr,
  input  logic            mem_arready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      mem_rresp,
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_addr
);

  localparam int unsigned TAG_W     = XLEN - 2;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      funct_q, funct_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_seen_q, flush_seen_d;
  logic [XLEN-1:0] rdata_d;
  logic            rready_d;
  logic            fault_d;
  logic [XLEN-1:0] fault_pc_d;
  logic            arvalid_d;
  logic [XLEN-1:0] araddr_d;
  logic            hit_c;
  logic [XLEN-1:0] hit_data_c;

  // Bits with no function in this block (the funct3 extension, and the snoop port when the buffer is absent)
  logic unused_bits;
  assign unused_bits = ^{exu_ralu[4:3], st_valid, st_addr};

  // Shift the word so the addressed byte is at bit 0, then sign- or zero-extend it.
  // funct3 values 011, 110 and 111 fall through to a plain word load.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] word,
                                               input logic [1:0]      off,
                                               input logic [2:0]      f3);
    logic [XLEN-1:0] w;
    w = word >> {off, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{(XLEN-8){w[7]}}, w[7:0]};
      3'b100:  fmt_load = {{(XLEN-8){1'b0}}, w[7:0]};
      3'b001:  fmt_load = {{(XLEN-16){w[15]}}, w[15:0]};
      3'b101:  fmt_load = {{(XLEN-16){1'b0}}, w[15:0]};
      default: fmt_load = w;
    endcase
  endfunction

  // A halfword must have address bit 0 clear. A word (and any reserved funct3) must have both low bits clear.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: is_misaligned = 1'b0;
      3'b001, 3'b101: is_misaligned = off[0];
      default:        is_misaligned = (off != 2'b00);
    endcase
  endfunction

`ifdef YSYX_LSU_LDRESP_LASTWORD_EN
  logic             buf_valid_q;
  logic [TAG_W-1:0] buf_tag_q;
  logic [XLEN-1:0]  buf_data_q;
  logic             snoop_req_c;
  logic             snoop_buf_c;
  logic             fill_c;

  // A store to the requested word in the hit cycle forces the miss path
  assign snoop_req_c = st_valid && (st_addr[XLEN-1:2] == exu_raddr[XLEN-1:2]);
  assign snoop_buf_c = st_valid && (st_addr[XLEN-1:2] == buf_tag_q);
  assign hit_c       = buf_valid_q && (buf_tag_q == exu_raddr[XLEN-1:2]) && !snoop_req_c;
  assign hit_data_c  = buf_data_q;
  assign fill_c      = (state_q == S_WAIT) && mem_rvalid && (mem_rresp == RESP_OKAY) && !flush &&
                       !(st_valid && (st_addr[XLEN-1:2] == addr_q[XLEN-1:2]));

  // Last-word buffer. A store snoop or a flush clears it; a fill of a new word takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
    end else begin
      if (flush || snoop_buf_c) buf_valid_q <= 1'b0;
      if (fill_c) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= TAG_W'(addr_q[XLEN-1:2]);
        buf_data_q  <= mem_rdata;
      end
    end
  end
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = '0;
`endif

  // Next state and next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct_d      = funct_q;
    pc_d         = pc_q;
    flush_seen_d = flush_seen_q;
    rdata_d      = exu_rdata;
    rready_d     = 1'b0;
    fault_d      = 1'b0;
    fault_pc_d   = ld_fault_pc;
    arvalid_d    = mem_arvalid;
    araddr_d     = mem_araddr;

    case (state_q)
      S_IDLE: begin
        if (exu_rvalid && !flush) begin
          addr_d  = exu_raddr;
          funct_d = exu_ralu[2:0];
          pc_d    = exu_pc;
          if (is_misaligned(exu_raddr[1:0], exu_ralu[2:0])) begin
            state_d    = S_RESP;
            rready_d   = 1'b1;
            fault_d    = 1'b1;
            rdata_d    = FAULT_DATA;
            fault_pc_d = exu_pc;
          end else if (hit_c) begin
            state_d  = S_RESP;
            rready_d = 1'b1;
            rdata_d  = fmt_load(hit_data_c, exu_raddr[1:0], exu_ralu[2:0]);
          end else begin
            state_d      = S_REQ;
            arvalid_d    = 1'b1;
            araddr_d     = {exu_raddr[XLEN-1:2], 2'b00};
            flush_seen_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (flush) flush_seen_d = 1'b1;
        if (mem_arready) begin
          arvalid_d = 1'b0;
          state_d   = (flush_seen_q || flush) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else if (mem_rresp != RESP_OKAY) begin
            state_d    = S_RESP;
            rready_d   = 1'b1;
            fault_d    = 1'b1;
            rdata_d    = FAULT_DATA;
            fault_pc_d = pc_q;
          end else begin
            state_d  = S_RESP;
            rready_d = 1'b1;
            rdata_d  = fmt_load(mem_rdata, addr_q[1:0], funct_q);
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      funct_q      <= '0;
      pc_q         <= '0;
      flush_seen_q <= 1'b0;
      exu_rdata    <= '0;
      exu_rready   <= 1'b0;
      ld_fault     <= 1'b0;
      ld_fault_pc  <= '0;
      mem_arvalid  <= 1'b0;
      mem_araddr   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct_q      <= funct_d;
      pc_q         <= pc_d;
      flush_seen_q <= flush_seen_d;
      exu_rdata    <= rdata_d;
      exu_rready   <= rready_d;
      ld_fault     <= fault_d;
      ld_fault_pc  <= fault_pc_d;
      mem_arvalid  <= arvalid_d;
      mem_araddr   <= araddr_d;
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_ldresp.sv
// Bench for ysyx_lsu_ldresp: directed cases followed by randomized loads, checked against a word-memory model.
module tb_ysyx_lsu_ldresp;

  localparam int unsigned XLEN = 32;
`ifdef YSYX_LSU_LDRESP_LASTWORD_EN
  localparam bit LW_EN = 1'b1;
`else
  localparam bit LW_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic            exu_rvalid;
  logic [XLEN-1:0] exu_raddr;
  logic [4:0]      exu_ralu;
  logic [XLEN-1:0] exu_pc;
  logic [XLEN-1:0] exu_rdata;
  logic            exu_rready;
  logic            ld_fault;
  logic [XLEN-1:0] ld_fault_pc;
  logic            mem_arvalid;
  logic [XLEN-1:0] mem_araddr;
  logic            mem_arready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic [1:0]      mem_rresp;
  logic            st_valid;
  logic [XLEN-1:0] st_addr;

  always #5 clock = ~clock;

  ysyx_lsu_ldresp #(.XLEN(XLEN), .FAULT_DATA('0)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .exu_rvalid(exu_rvalid), .exu_raddr(exu_raddr), .exu_ralu(exu_ralu), .exu_pc(exu_pc),
    .exu_rdata(exu_rdata), .exu_rready(exu_rready), .ld_fault(ld_fault), .ld_fault_pc(ld_fault_pc),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .st_valid(st_valid), .st_addr(st_addr)
  );

  int checks = 0;
  int errors = 0;

  // Model state: word memory, the last fault pc, and the last-word buffer as seen from outside
  logic [31:0] mem_m [logic [29:0]];
  logic [31:0] fault_pc_m = '0;
  bit          lw_valid = 1'b0;
  logic [29:0] lw_tag = '0;
  logic [31:0] lw_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned access_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  // Result of a load: select the addressed byte or halfword arithmetically, then extend it
  function automatic logic [31:0] load_ref(input logic [31:0] word, input logic [31:0] addr, input logic [2:0] f3);
    int unsigned v;
    int unsigned b;
    int unsigned h;
    v = word / (32'd1 << (8 * (addr % 4)));
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // Run one load from the current falling edge. The bench plays the memory side with the given delays.
  // A non-negative flush_at pulses flush in that cycle, and then no response may appear.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [1:0] resp, input int ar_delay, input int rv_delay, input int flush_at);
    logic [29:0] tg;
    logic [31:0] word;
    logic [31:0] exp_data;
    bit mis, hit, flushed, exp_fault, ar_seen, hs_done, got;
    int hs_t, ar_cnt, lat, exp_lat;
    tg = addr[31:2];
    if (!mem_m.exists(tg)) mem_m[tg] = $urandom();
    word    = mem_m[tg];
    mis     = (addr % access_size(f3)) != 0;
    hit     = LW_EN && !mis && lw_valid && (lw_tag == tg);
    flushed = (flush_at >= 0);
    if (mis) begin
      exp_fault = 1'b1; exp_data = '0; exp_lat = 1;
    end else if (hit) begin
      exp_fault = 1'b0; exp_data = load_ref(lw_data, addr, f3); exp_lat = 1;
    end else if (resp != 2'd0) begin
      exp_fault = 1'b1; exp_data = '0; exp_lat = 3 + ar_delay + rv_delay;
    end else begin
      exp_fault = 1'b0; exp_data = load_ref(word, addr, f3); exp_lat = 3 + ar_delay + rv_delay;
    end
    ar_seen = 1'b0; hs_done = 1'b0; got = 1'b0; hs_t = -100; ar_cnt = 0; lat = -1;

    exu_rvalid = 1'b1;
    exu_raddr  = addr;
    exu_ralu   = {2'($urandom_range(0, 3)), f3};
    exu_pc     = pc;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clock);
      mem_arready = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rresp   = 2'($urandom_range(0, 3));
      mem_rdata   = $urandom();
      flush       = 1'b0;
      if (got) begin
        check("rready_single_cycle", exu_rready, 1'b0);
        break;
      end
      if (exu_rready) begin
        got = 1'b1;
        lat = t;
        check("rdata", exu_rdata, exp_data);
        check("ld_fault", ld_fault, exp_fault);
        exu_rvalid = 1'b0;
      end
      if (ar_seen && !hs_done) check("arvalid_held", mem_arvalid, 1'b1);
      else if (hs_done) check("arvalid_drop", mem_arvalid, 1'b0);
      else if (mem_arvalid) begin
        ar_seen = 1'b1;
        check("araddr", mem_araddr, addr & 32'hFFFF_FFFC);
      end
      if (mem_arvalid && !hs_done) begin
        if (ar_cnt == ar_delay) begin
          mem_arready = 1'b1; hs_done = 1'b1; hs_t = t;
        end else begin
          ar_cnt++;
        end
      end
      if (t == hs_t + 1 + rv_delay) begin
        mem_rvalid = 1'b1; mem_rdata = word; mem_rresp = resp;
      end
      if (t == flush_at) begin
        flush = 1'b1; exu_rvalid = 1'b0;
      end
      if (flushed && hs_done && t > hs_t + rv_delay + 3) break;
    end
    check("mem_request", 32'(ar_seen), 32'(!(mis || hit)));
    if (flushed) begin
      check("no_resp_after_flush", 32'(got), 32'd0);
      lw_valid = 1'b0;
    end else begin
      check("latency", lat, exp_lat);
      if (exp_fault) fault_pc_m = pc;
      if (!mis && !hit && resp == 2'd0) begin
        lw_valid = 1'b1; lw_tag = tg; lw_data = word;
      end
    end
    check("ld_fault_pc", ld_fault_pc, fault_pc_m);
    exu_rvalid = 1'b0;
    flush      = 1'b0;
  endtask

  // A store snoop in an idle cycle: memory gets a new word and the buffered copy is no longer valid
  task automatic store_snoop(input logic [31:0] a);
    st_valid = 1'b1;
    st_addr  = a;
    @(negedge clock);
    st_valid = 1'b0;
    if (lw_valid && lw_tag == a[31:2]) lw_valid = 1'b0;
    mem_m[a[31:2]] = $urandom();
  endtask

  // A request that meets flush in IDLE must not be accepted (it would fault on the next edge if taken)
  task automatic idle_flush();
    exu_rvalid = 1'b1;
    exu_raddr  = 32'h8000_0001;
    exu_ralu   = 5'b00010;
    exu_pc     = 32'h0000_0BAD;
    flush      = 1'b1;
    @(negedge clock);
    flush      = 1'b0;
    exu_rvalid = 1'b0;
    check("idle_flush_rready", exu_rready, 1'b0);
    check("idle_flush_arvalid", mem_arvalid, 1'b0);
    lw_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; exu_rvalid = 1'b0; exu_raddr = '0; exu_ralu = '0; exu_pc = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
    st_valid = 1'b0; st_addr = '0;
    repeat (3) @(negedge clock);
    check("reset_rready", exu_rready, 1'b0);
    check("reset_rdata", exu_rdata, 32'h0);
    check("reset_fault", ld_fault, 1'b0);
    check("reset_fault_pc", ld_fault_pc, 32'h0);
    check("reset_arvalid", mem_arvalid, 1'b0);
    check("reset_araddr", mem_araddr, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Word load with minimum latency
    mem_m[30'h2000_0001] = 32'hDEAD_BEEF;
    run_load(32'h8000_0004, 3'b010, 32'h0000_1000, 2'd0, 0, 0, -1);
    check("lw_literal", exu_rdata, 32'hDEAD_BEEF);
    // Byte loads, signed and unsigned
    mem_m[30'h2000_0000] = 32'h80FF_0000;
    run_load(32'h8000_0003, 3'b000, 32'h0000_1004, 2'd0, 0, 0, -1);
    check("lb_literal", exu_rdata, 32'hFFFF_FF80);
    run_load(32'h8000_0003, 3'b100, 32'h0000_1008, 2'd0, 0, 0, -1);
    check("lbu_literal", exu_rdata, 32'h0000_0080);
    // Misaligned halfword
    run_load(32'h8000_0001, 3'b001, 32'h0000_100C, 2'd0, 0, 0, -1);
    check("mis_fault_pc_literal", ld_fault_pc, 32'h0000_100C);
    // Flush while waiting for data, then while the request is still pending, each followed by a clean load
    run_load(32'h8000_0008, 3'b010, 32'h0000_1010, 2'd0, 4, 3, 7);
    run_load(32'h8000_0008, 3'b010, 32'h0000_1014, 2'd0, 0, 0, -1);
    run_load(32'h8000_000C, 3'b010, 32'h0000_1018, 2'd0, 4, 1, 2);
    run_load(32'h8000_000C, 3'b010, 32'h0000_101C, 2'd0, 1, 2, -1);
    // Bus error, then a retry
    mem_m[30'h2000_0000] = 32'h1234_5678;
    run_load(32'h8000_0002, 3'b101, 32'h0000_1020, 2'd2, 0, 0, -1);
    run_load(32'h8000_0002, 3'b101, 32'h0000_1024, 2'd0, 0, 0, -1);
    check("lhu_literal", exu_rdata, 32'h0000_1234);
    // Repeated access to one word, with and without a store snoop in between
    run_load(32'h0000_0100, 3'b010, 32'h0000_1028, 2'd0, 0, 0, -1);
    run_load(32'h0000_0101, 3'b100, 32'h0000_102C, 2'd0, 0, 0, -1);
    run_load(32'h0000_0100, 3'b010, 32'h0000_1030, 2'd0, 0, 0, -1);
    store_snoop(32'h0000_0102);
    run_load(32'h0000_0101, 3'b100, 32'h0000_1034, 2'd0, 0, 0, -1);
    idle_flush();
    run_load(32'h0000_0101, 3'b000, 32'h0000_1038, 2'd0, 0, 1, -1);

    // Randomized loads over a small window of words so that repeats happen
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [1:0]  r;
      a = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      r = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      run_load(a, 3'($urandom_range(0, 7)), $urandom(), r,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      if ($urandom_range(0, 5) == 0)
        store_snoop(32'h8000_0000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) idle_flush();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
